// File: rtl/cnn_layer_accel_fas_vec_sum_rdr.sv
// cnn_layer_accel_fas_vec_sum_rdr: captures one kernel depth of summed vectors, then replays it once per 1x1 kernel.
module cnn_layer_accel_fas_vec_sum_rdr #(
  parameter int VEC_WIDTH = 128,
  parameter int DEPTH     = 64,
  parameter int ADDR_WTH  = $clog2(DEPTH)
) (
  input  logic                 clk_FAS,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [15:0]          krnl1x1_dpth_end_cfg,
  input  logic [15:0]          krnl1x1_end_cfg,
  input  logic                 sum_in_valid,
  output logic                 sum_in_ready,
  input  logic [VEC_WIDTH-1:0] sum_in_data,
  output logic                 sum_out_valid,
  input  logic                 sum_out_ready,
  output logic [VEC_WIDTH-1:0] sum_out_data,
  output logic                 sum_out_last_dpth,
  output logic                 sum_out_last_krnl,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, FILL, REPLAY} state_t;
  state_t                r_state;
  logic [VEC_WIDTH-1:0]  r_buf [DEPTH];
  logic [ADDR_WTH-1:0]   r_wr_addr, r_rd_addr, r_dpth_end;
  logic [15:0]           r_krnl_end, r_krnl_cnt;
  logic                  r_stop, r_in_rdy, r_out_vld, r_last_dpth, r_last_krnl, r_busy, r_done;
  logic [VEC_WIDTH-1:0]  r_out_data;
  logic                  w_in_acc, w_fill_end, w_out_acc, w_load, w_ld_dpth, w_ld_krnl;
  logic [ADDR_WTH-1:0]   w_rd_cur, w_dpth_clamp;
  logic [15:0]           w_kc_cur;
  logic [VEC_WIDTH-1:0]  w_rd_data;
  assign w_in_acc     = sum_in_valid && r_in_rdy;
  assign w_fill_end   = w_in_acc && (r_wr_addr == r_dpth_end);
  assign w_out_acc    = r_out_vld && sum_out_ready;
  // The last fill beat preloads buf[0] so replay starts with no bubble.
  assign w_load       = w_fill_end || (r_state == REPLAY && !r_stop && (!r_out_vld || sum_out_ready));
  assign w_rd_cur     = (r_state == FILL) ? '0 : r_rd_addr;
  assign w_kc_cur     = (r_state == FILL) ? '0 : r_krnl_cnt;
  // With a single-entry depth, buf[0] is being written in this very cycle.
  assign w_rd_data    = (r_state == FILL && r_wr_addr == '0) ? sum_in_data : r_buf[w_rd_cur];
  assign w_ld_dpth    = (w_rd_cur == r_dpth_end);
  assign w_ld_krnl    = (w_kc_cur == r_krnl_end);
  assign w_dpth_clamp = (krnl1x1_dpth_end_cfg > 16'(DEPTH - 1)) ? ADDR_WTH'(DEPTH - 1)
                                                              : krnl1x1_dpth_end_cfg[ADDR_WTH-1:0];
  always_ff @(posedge clk_FAS)
    if (w_in_acc) r_buf[r_wr_addr] <= sum_in_data;
  always_ff @(posedge clk_FAS or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_dpth_end  <= '0;
      r_krnl_end  <= '0;
      r_krnl_cnt  <= '0;
      r_stop      <= 1'b0;
      r_in_rdy    <= 1'b0;
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_last_dpth <= 1'b0;
      r_last_krnl <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_out_vld   <= 1'b1;
        r_out_data  <= w_rd_data;
        r_last_dpth <= w_ld_dpth;
        r_last_krnl <= w_ld_krnl;
        r_rd_addr   <= w_ld_dpth ? '0 : w_rd_cur + 1'b1;
        r_krnl_cnt  <= w_kc_cur + 16'(w_ld_dpth);
        r_stop      <= w_ld_dpth && w_ld_krnl;
      end else if (w_out_acc) begin
        r_out_vld <= 1'b0;
      end
      case (r_state)
        IDLE: if (start) begin
          r_dpth_end <= w_dpth_clamp;
          r_krnl_end <= krnl1x1_end_cfg;
          r_wr_addr  <= '0;
          r_rd_addr  <= '0;
          r_krnl_cnt <= '0;
          r_stop     <= 1'b0;
          r_in_rdy   <= 1'b1;
          r_busy     <= 1'b1;
          r_state    <= FILL;
        end
        FILL: if (w_in_acc) begin
          r_wr_addr <= r_wr_addr + 1'b1;
          if (w_fill_end) begin
            r_in_rdy <= 1'b0;
            r_state  <= REPLAY;
          end
        end
        REPLAY: if (w_out_acc && r_stop) begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign sum_in_ready      = r_in_rdy;
  assign sum_out_valid     = r_out_vld;
  assign sum_out_data      = r_out_data;
  assign sum_out_last_dpth = r_last_dpth;
  assign sum_out_last_krnl = r_last_krnl;
  assign busy              = r_busy;
  assign done              = r_done;
endmodule

// File: tb/tb_cnn_layer_accel_fas_vec_sum_rdr.sv
// tb_cnn_layer_accel_fas_vec_sum_rdr: randomized replay-reader bench against a queue-based expected-stream model.
module tb_cnn_layer_accel_fas_vec_sum_rdr;
  localparam int VW = 128;
  localparam int DP = 64;
  logic clk_FAS = 0, rst_n = 0, start = 0, in_v = 0, out_r = 0;
  logic [15:0] dcfg = 0, kcfg = 0;
  logic [VW-1:0] in_d = '0;
  logic in_r, out_v, ld, lk, busy, done;
  logic [VW-1:0] out_d;
  int tests = 0, fails = 0, popped = 0;
  typedef struct packed { logic [VW-1:0] d; logic ld; logic lk; } beat_t;
  beat_t exp_q[$], obs_q[$], pb, e;
  logic pv = 0, pr = 0;

  cnn_layer_accel_fas_vec_sum_rdr #(.VEC_WIDTH(VW), .DEPTH(DP)) dut (
    .clk_FAS(clk_FAS), .rst_n(rst_n), .start(start),
    .krnl1x1_dpth_end_cfg(dcfg), .krnl1x1_end_cfg(kcfg),
    .sum_in_valid(in_v), .sum_in_ready(in_r), .sum_in_data(in_d),
    .sum_out_valid(out_v), .sum_out_ready(out_r), .sum_out_data(out_d),
    .sum_out_last_dpth(ld), .sum_out_last_krnl(lk), .busy(busy), .done(done));

  always #5 clk_FAS = ~clk_FAS;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Scoreboard: every accepted beat must match the next expected beat; stalled beats must hold.
  always @(negedge clk_FAS) begin
    if (!rst_n) pv = 0;
    else begin
      if (pv && !pr) begin
        chk("stall_valid", out_v, 1);
        chk("stall_data", out_d, pb.d);
        chk("stall_last_dpth", ld, pb.ld);
        chk("stall_last_krnl", lk, pb.lk);
      end
      if (out_v && out_r) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat_data", out_d, e.d);
          chk("beat_last_dpth", ld, e.ld);
          chk("beat_last_krnl", lk, e.lk);
        end
        obs_q.push_back('{out_d, ld, lk});
        popped++;
      end
      pv = out_v; pr = out_r; pb = '{out_d, ld, lk};
    end
  end

  task automatic chk_zero(input string name);
    chk({name, "_in_ready"}, in_r, 0);
    chk({name, "_out_valid"}, out_v, 0);
    chk({name, "_out_data"}, out_d, 0);
    chk({name, "_last_dpth"}, ld, 0);
    chk({name, "_last_krnl"}, lk, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
  endtask

  // mode 0: sum_out_ready high; mode 1: random valid/ready. abort_at: beat index to reset on (-1 none).
  task automatic run(input int dc, input int kc, input int mode, input bit fixed,
                     input logic [VW-1:0] base, input bit poke, input int abort_at);
    int d, n, acc, guard, cyc;
    bit was;
    logic [VW-1:0] v [DP];
    d = (dc > DP - 1) ? DP - 1 : dc;
    n = (d + 1) * (kc + 1);
    for (int i = 0; i <= d; i++)
      v[i] = fixed ? base + VW'(i) : {$urandom, $urandom, $urandom, $urandom};
    exp_q.delete();
    obs_q.delete();
    popped = 0;
    for (int k = 0; k <= kc; k++)
      for (int i = 0; i <= d; i++) exp_q.push_back('{v[i], i == d, k == kc});
    dcfg = 16'(dc); kcfg = 16'(kc); start = 1;
    @(posedge clk_FAS) #1;
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("ready_after_start", in_r, 1);
    chk("done_low_after_start", done, 0);
    acc = 0; guard = 0;
    while (acc <= d && guard < 2000) begin
      in_v = (mode == 1) ? 1'($urandom % 2) : 1'b1;
      in_d = v[acc];
      if (poke && acc == 1) begin start = 1; dcfg = 16'($urandom); kcfg = 16'($urandom); end
      was = in_v && in_r;
      @(posedge clk_FAS) #1;
      start = 0;
      if (was) acc++;
      guard++;
    end
    in_v = 0;
    chk("fill_count", acc, d + 1);
    chk("ready_drop_after_fill", in_r, 0);
    chk("first_out_valid", out_v, 1);
    cyc = 0;
    while (!done && cyc < 5000) begin
      out_r = (mode == 1) ? 1'($urandom % 2) : 1'b1;
      if (poke && cyc == 3) begin start = 1; dcfg = 16'($urandom); kcfg = 16'($urandom); end
      if (popped == abort_at) begin
        #2 rst_n = 0;
        #1 chk_zero("reset_mid_replay");
        exp_q.delete();
        out_r = 0;
        repeat (2) @(posedge clk_FAS);
        #3 rst_n = 1;
        @(posedge clk_FAS) #1;
        chk("idle_after_reset_busy", busy, 0);
        return;
      end
      @(posedge clk_FAS) #1;
      start = 0;
      cyc++;
      if (poke && !done) chk("ready_low_in_replay", in_r, 0);
    end
    chk("done_seen", done, 1);
    chk("done_out_valid", out_v, 0);
    chk("done_busy", busy, 0);
    chk("done_in_ready", in_r, 0);
    chk("all_beats_out", exp_q.size(), 0);
    chk("beat_count", obs_q.size(), n);
    if (mode == 0) chk("replay_cycles", cyc, n);
    out_r = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk_FAS);
    #1 chk_zero("reset");
    rst_n = 1;
    @(posedge clk_FAS) #1;
    run(3, 2, 0, 1, VW'('hA0), 0, -1);
    chk("t1_size", obs_q.size(), 12);
    chk("t1_b0", obs_q[0].d, VW'('hA0));
    chk("t1_b5", obs_q[5].d, VW'('hA1));
    chk("t1_b11", obs_q[11].d, VW'('hA3));
    chk("t1_ld3", obs_q[3].ld, 1);
    chk("t1_ld4", obs_q[4].ld, 0);
    chk("t1_lk7", obs_q[7].lk, 0);
    chk("t1_lk8", obs_q[8].lk, 1);
    chk("t1_ld11", obs_q[11].ld, 1);
    run(3, 2, 1, 1, VW'('hA0), 0, -1);
    chk("t2_b9", obs_q[9].d, VW'('hA1));
    chk("t2_lk11", obs_q[11].lk, 1);
    run(0, 0, 0, 1, VW'('h55), 0, -1);
    chk("t3_size", obs_q.size(), 1);
    chk("t3_data", obs_q[0].d, VW'('h55));
    chk("t3_ld", obs_q[0].ld, 1);
    chk("t3_lk", obs_q[0].lk, 1);
    run(3, 2, 1, 0, '0, 1, -1);
    run(3, 2, 0, 0, '0, 0, 6);
    run(1, 0, 0, 0, '0, 0, -1);
    chk("t5_size", obs_q.size(), 2);
    run(200, 1, 0, 0, '0, 0, -1);
    chk("t6_ld62", obs_q[62].ld, 0);
    chk("t6_ld63", obs_q[63].ld, 1);
    chk("t6_ld127", obs_q[127].ld, 1);
    for (int t = 0; t < 8; t++)
      run($urandom_range(0, 12), $urandom_range(0, 3), $urandom % 2, 0, '0, 0, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cnn_layer_accel_fas_vec_sum_rdr.md
# cnn_layer_accel_fas_vec_sum_rdr

Replay reader for the FAS vector-sum path. It captures one full kernel depth of summed vectors (conv + partial/residual map sums) into a local buffer. It then streams that depth back out once per 1x1 kernel, so the 1x1 convolution stage can reuse the entire summed depth without re-reading the source FIFOs. It sits between the FAS vector adder output and the 1x1 kernel datapath.

## Interface
Parameters:
- VEC_WIDTH, 128, width of one summed vector (SIMD lanes × pixel width)
- DEPTH, 64, buffer entries; maximum 1x1 kernel depth in vectors
- ADDR_WTH, $clog2(DEPTH), buffer address width

Ports:
- clk_FAS  input  1  single clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle pulse; latches the config inputs and begins a fill
- krnl1x1_dpth_end_cfg  input  16  index of the last depth vector (vector count − 1)
- krnl1x1_end_cfg  input  16  index of the last 1x1 kernel (pass count − 1)
- sum_in_valid  input  1  input vector valid
- sum_in_ready  output  1  input vector accepted when valid && ready
- sum_in_data  input  VEC_WIDTH  summed vector from the adder
- sum_out_valid  output  1  output vector valid
- sum_out_ready  input  1  downstream accepts the output
- sum_out_data  output  VEC_WIDTH  replayed vector, registered
- sum_out_last_dpth  output  1  current beat is the last depth index of a pass
- sum_out_last_krnl  output  1  current beat belongs to the last pass
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the final beat is accepted

## Operation
- States: IDLE, FILL, REPLAY.
- IDLE:
  - On start, latch dpth_end = min(krnl1x1_dpth_end_cfg, DEPTH−1) and krnl_end = krnl1x1_end_cfg.
  - Clear wr_addr, rd_addr and krnl_cnt; go to FILL.
- FILL:
  - sum_in_ready = 1.
  - Each accepted beat writes buf[wr_addr] and increments wr_addr.
  - The beat accepted with wr_addr == dpth_end moves the block to REPLAY.
- REPLAY:
  - The output register loads buf[rd_addr] whenever it is empty or is being consumed in the same cycle.
  - rd_addr wraps from dpth_end to 0; each wrap increments krnl_cnt.
  - Each beat is tagged with last_dpth = (rd_addr == dpth_end) and last_krnl = (krnl_cnt == krnl_end).
  - Loading stops after the beat tagged last_dpth && last_krnl.
  - When that beat is accepted: done pulses and the block returns to IDLE.
- start is ignored while busy. sum_in_ready = 0 outside FILL.
- Data passes through bit-exact; the block performs no arithmetic.
- Counters are 16-bit, except the buffer addresses, which are ADDR_WTH bits.
- The clamp on dpth_end guarantees the buffer addresses never exceed DEPTH−1.

## Timing
- Reset values:
  - sum_in_ready = 0, sum_out_valid = 0, sum_out_data = 0
  - sum_out_last_dpth = 0, sum_out_last_krnl = 0
  - busy = 0, done = 0
  - State IDLE; all counters 0.
  - Buffer contents are undefined and need no reset.
- Start to fill: start sampled at cycle 0 → sum_in_ready = 1 and busy = 1 at cycle 1.
- Fill to replay: last input accepted at cycle t → sum_out_valid = 1 with buf[0] at cycle t+1. No bubble.
- Throughput: one beat per cycle while sum_out_ready is held high, including across pass boundaries.
- Backpressure: with sum_out_valid high and sum_out_ready low, data and tags hold stable.
- Done: final beat accepted at cycle u → done = 1 at cycle u+1 only; sum_out_valid = 0, busy = 0, sum_in_ready = 0 at u+1.
- A start pulse at cycle u+1 is accepted.
- Reset assertion in any state asynchronously forces all outputs to their reset values; operation resumes only on a new start.
- dpth_end = 0: each pass is a single beat, and every beat has last_dpth = 1.
- krnl_end = 0: a single pass.

## Test plan
- dpth_end = 3, krnl_end = 2, inputs 0xA0..0xA3, sum_out_ready tied high:
  - Output is A0,A1,A2,A3 repeated 3 times on 12 consecutive cycles.
  - last_dpth = 1 on beats 3, 7 and 11; last_krnl = 1 on beats 8–11.
  - done pulses one cycle after beat 11.
- Same config, sum_out_ready toggled randomly (50%):
  - Identical 12-beat sequence with no drops or duplicates.
  - Data and tags hold stable throughout every stall.
- dpth_end = 0, krnl_end = 0, input 0x55:
  - Exactly one beat 0x55 with both tags = 1, then done.
- start pulsed during FILL and again during REPLAY:
  - Both pulses are ignored; latched config and output stream are unchanged.
  - sum_in_ready stays 0 during REPLAY.
- rst_n asserted mid-REPLAY (pass 1, beat 2):
  - All outputs 0 in the same cycle.
  - After release, a new start with dpth_end = 1, krnl_end = 0 produces a correct 2-beat stream.
- krnl1x1_dpth_end_cfg = 200 with DEPTH = 64:
  - Fill accepts exactly 64 beats; each pass replays 64 beats; last_dpth = 1 on index 63.
